refill_arbiter: RTL and testbench

REFILL_ARBITER -- requirements
Module: refill_arbiter

---
 rtl/refill_arbiter.sv | 126 ++++++++++++
 tb/tb_refill_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/refill_arbiter.sv
// Two-requester cache refill arbiter onto a single AXI read channel.
// Round-robin grant, one outstanding burst, beat counting with length check.
module refill_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_aclk,
  input  logic                 i_areset,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic [ADDR_SIZE-1:0] i_addr0,
  input  logic [ADDR_SIZE-1:0] i_addr1,
  input  logic [7:0]           i_len0,
  input  logic [7:0]           i_len1,
  output logic                 o_ack0,
  output logic                 o_ack1,
  output logic                 o_rvalid0,
  output logic                 o_rvalid1,
  output logic                 o_rlast,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic [1:0]           o_rresp,
  output logic                 o_len_err,
  output logic [ADDR_SIZE-1:0] o_araddr,
  output logic [7:0]           o_arlen,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  output logic [1:0]           o_arburst,
  output logic [2:0]           o_arsize,
  input  logic [DATA_SIZE-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  input  logic                 i_rlast,
  input  logic                 i_rvalid,
  output logic                 o_rready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 owner_q, owner_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] araddr_q, araddr_d;
  logic [7:0]           arlen_q, arlen_d;

  logic in_addr, in_data, beat, cnt_hit, burst_end, grant;

  assign in_addr   = (state_q == ADDR);
  assign in_data   = (state_q == DATA);
  assign beat      = in_data & i_rvalid;
  assign cnt_hit   = (cnt_q == arlen_q);
  assign burst_end = beat & (i_rlast | cnt_hit);
  // Pointer only matters on contention; a lone requester always wins.
  assign grant     = (i_req0 & i_req1) ? ptr_q : i_req1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    unique case (state_q)
      IDLE: begin
        if (i_req0 | i_req1) begin
          state_d  = ADDR;
          owner_d  = grant;
          araddr_d = grant ? i_addr1 : i_addr0;
          arlen_d  = grant ? i_len1 : i_len0;
        end
      end
      ADDR: begin
        if (i_arready) begin
          state_d = DATA;
          cnt_d   = 8'd0;
        end
      end
      DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          if (burst_end) begin
            state_d = IDLE;
            ptr_d   = ~owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= 8'd0;
      araddr_q <= '0;
      arlen_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
    end
  end

  assign o_arvalid = in_addr;
  assign o_araddr  = araddr_q;
  assign o_arlen   = arlen_q;
  assign o_arburst = 2'b01;
  assign o_arsize  = 3'b010;
  assign o_ack0    = in_addr & i_arready & ~owner_q;
  assign o_ack1    = in_addr & i_arready & owner_q;

  assign o_rready  = in_data;
  assign o_rvalid0 = beat & ~owner_q;
  assign o_rvalid1 = beat & owner_q;
  assign o_rlast   = in_data & i_rlast;
  assign o_rdata   = in_data ? i_rdata : '0;
  assign o_rresp   = in_data ? i_rresp : 2'b00;
  assign o_len_err = beat & (i_rlast ^ cnt_hit);

endmodule

// File: tb/tb_refill_arbiter.sv
// Transaction-level bench for refill_arbiter: directed scenarios
// followed by randomized bursts against a round-robin reference.
module tb_refill_arbiter;

  logic        clk = 0;
  logic        i_areset;
  logic        i_req0, i_req1;
  logic [31:0] i_addr0, i_addr1;
  logic [7:0]  i_len0, i_len1;
  logic        o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_rlast, o_len_err;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic        o_arvalid, i_arready;
  logic [1:0]  o_arburst;
  logic [2:0]  o_arsize;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rlast, i_rvalid, o_rready;

  int vectors = 0;
  int miscompares = 0;
  bit ptr_m = 0;

  always #5 clk = ~clk;

  refill_arbiter dut (
    .i_aclk(clk), .i_areset(i_areset),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_addr0(i_addr0), .i_addr1(i_addr1),
    .i_len0(i_len0), .i_len1(i_len1),
    .o_ack0(o_ack0), .o_ack1(o_ack1),
    .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rlast(o_rlast), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_len_err(o_len_err),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .o_arburst(o_arburst), .o_arsize(o_arsize),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    i_areset = 1;
    step();
    i_areset = 0;
    ptr_m = 0;
  endtask

  // mode 0: rlast on final beat, 1: early rlast at ebeat, 2: rlast never
  task automatic do_burst(input bit r0, input bit r1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [7:0] l0, input logic [7:0] l1,
                          input int ard, input int mode, input int ebeat,
                          input int abort);
    bit w, fin, rl;
    logic [31:0] a;
    logic [7:0] l;
    int k;
    i_req0 = r0; i_req1 = r1;
    i_addr0 = a0; i_addr1 = a1;
    i_len0 = l0; i_len1 = l1;
    i_arready = 0;
    i_rlast = 0;
    i_rvalid = 1'($urandom);
    w = (r0 && r1) ? ptr_m : r1;
    a = w ? a1 : a0;
    l = w ? l1 : l0;
    @(negedge clk);
    chk("idle_arvalid", o_arvalid, 0);
    chk("idle_rvalid", {o_rvalid1, o_rvalid0}, 0);
    chk("idle_rready", o_rready, 0);
    step();
    for (int i = 0; i < ard; i++) begin
      i_addr0 = $urandom; i_addr1 = $urandom;
      i_len0 = 8'($urandom); i_len1 = 8'($urandom);
      i_rvalid = 1'($urandom);
      @(negedge clk);
      chk("stall_arvalid", o_arvalid, 1);
      chk("stall_araddr", o_araddr, a);
      chk("stall_arlen", o_arlen, l);
      chk("stall_ack", {o_ack1, o_ack0}, 0);
      chk("stall_rvalid", {o_rvalid1, o_rvalid0}, 0);
      step();
    end
    i_arready = 1;
    i_rvalid = 0;
    @(negedge clk);
    chk("hs_ack", {o_ack1, o_ack0}, w ? 2'b10 : 2'b01);
    chk("hs_araddr", o_araddr, a);
    chk("hs_arlen", o_arlen, l);
    chk("hs_burst", {o_arburst, o_arsize}, 5'b01_010);
    step();
    i_arready = 0;
    if (w) i_req1 = 0; else i_req0 = 0;
    k = 0;
    fin = 0;
    while (!fin) begin
      if (k == abort) begin
        i_req0 = 0; i_req1 = 0;
        i_rvalid = 1;
        i_areset = 1;
        #1;
        chk("rst_outs", {o_arvalid, o_araddr, o_arlen, o_rready,
            o_rvalid0, o_rvalid1, o_ack0, o_ack1, o_len_err}, 0);
        step();
        i_areset = 0;
        @(negedge clk);
        chk("post_rst_rvalid", {o_rvalid1, o_rvalid0}, 0);
        chk("post_rst_rready", o_rready, 0);
        step();
        i_rvalid = 0;
        ptr_m = 0;
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        i_rvalid = 0;
        @(negedge clk);
        chk("gap_rready", o_rready, 1);
        chk("gap_rvalid", {o_rvalid1, o_rvalid0}, 0);
        step();
      end
      rl = (mode == 0) ? (k == int'(l)) : (mode == 1) ? (k == ebeat) : 0;
      i_rvalid = 1;
      i_rlast = rl;
      i_rdata = $urandom;
      i_rresp = 2'($urandom);
      @(negedge clk);
      chk("beat_rvalid", {o_rvalid1, o_rvalid0}, w ? 2'b10 : 2'b01);
      chk("beat_rdata", o_rdata, i_rdata);
      chk("beat_rresp", o_rresp, i_rresp);
      chk("beat_rlast", o_rlast, rl);
      chk("beat_len_err", o_len_err, rl != (k == int'(l)));
      step();
      i_rvalid = 0;
      i_rlast = 0;
      if (rl || k == int'(l)) begin
        fin = 1;
        ptr_m = ~w;
      end
      k++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit r0, r1;
    int m, e, lr;
    i_areset = 1;
    i_req0 = 0; i_req1 = 0;
    i_addr0 = 0; i_addr1 = 0;
    i_len0 = 0; i_len1 = 0;
    i_arready = 0;
    i_rdata = 0; i_rresp = 0; i_rlast = 0; i_rvalid = 0;
    #3;
    chk("reset_outs", {o_arvalid, o_araddr, o_arlen, o_rready,
        o_rvalid0, o_rvalid1, o_ack0, o_ack1, o_len_err}, 0);
    step();
    i_areset = 0;

    do_burst(1, 0, 32'h1000, 32'h0, 8'd3, 8'd0, 2, 0, 0, -1);

    reset_pulse();
    do_burst(1, 1, 32'hA000, 32'hB000, 8'd1, 8'd2, 0, 0, 0, -1);
    do_burst(1, 1, 32'hA040, 32'hB040, 8'd0, 8'd1, 1, 0, 0, -1);
    do_burst(1, 1, 32'hA080, 32'hB080, 8'd2, 8'd0, 0, 0, 0, -1);
    do_burst(1, 1, 32'hA0C0, 32'hB0C0, 8'd1, 8'd1, 0, 0, 0, -1);

    for (int i = 0; i < 3; i++)
      do_burst(0, 1, 32'h0, 32'hC000 + 32'(i * 64), 8'd0, 8'd2, 0, 0, 0, -1);

    do_burst(1, 0, 32'h2000, 32'h0, 8'd3, 8'd0, 0, 1, 1, -1);
    do_burst(1, 0, 32'h3000, 32'h0, 8'd3, 8'd0, 0, 2, 0, -1);

    do_burst(1, 0, 32'h4000, 32'h0, 8'd3, 8'd0, 5, 0, 0, 1);
    do_burst(1, 1, 32'h5000, 32'h6000, 8'd1, 8'd1, 0, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      lr = $urandom_range(0, 7);
      m = $urandom_range(0, 2);
      e = 0;
      if (m == 1) begin
        if (lr == 0) m = 0;
        else e = $urandom_range(0, lr - 1);
      end
      do_burst(r0, r1, $urandom, $urandom, 8'(lr), 8'(lr),
               $urandom_range(0, 3), m, e, -1);
    end

    @(negedge clk);
    chk("final_idle", {o_arvalid, o_rready}, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
